fp_alu_ctrl: RTL and testbench
==============================

# fp_alu_ctrl

Sequential front-end for the combinational `FP_ALU` in the FP coprocessor path. Accepts one FP operation at a time from the issue stage over a valid/ready handshake and drives operands and function code into `FP_ALU`. After a programmable settle time it captures the result and exception flags, presents them on a valid/ready response port, and keeps FCSR-style sticky flags and compare condition bits.

## Interface

Parameters:
- `LATENCY`, default 1: cycles operands are held on the ALU before capture. Legal range is 1..15.
- `TAG_W`, default 5: width of the destination tag passed through with each operation.

Ports (flag vectors use the order `{SNaN, QNaN, div_by_zero, inexact, underflow, overflow}` = bits [5:0]):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_func`  in  3  000 add, 001 sub, 010 mul, 011 div, 100 cmp, 101 inv, 110 round, 111 illegal.
- `req_a`, `req_b`  in  32  IEEE-754 single operands.
- `req_tag`  in  TAG_W  destination tag.
- `alu_num1`, `alu_num2`  out  32  to `FP_ALU.num1` / `FP_ALU.num2`.
- `alu_func`  out  3  to `FP_ALU.func`.
- `alu_result`  in  32  from `FP_ALU.result`.
- `alu_flags`  in  6  from the `FP_ALU` flag outputs, in the order above.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_result`  out  32  captured result.
- `rsp_flags`  out  6  captured flags.
- `rsp_tag`  out  TAG_W  tag of the operation.
- `rsp_illegal`  out  1  operation had func 111.
- `trap_en`  in  6  per-flag trap enable.
- `exc_trap`  out  1  `rsp_valid & |(rsp_flags & trap_en)`.
- `fcsr_flags`  out  6  sticky OR of all captured flags.
- `fcsr_clr`  in  1  synchronous clear of `fcsr_flags`.
- `cc`  out  3  `{lt, eq, gt}` from the last completed cmp.

## Operation

The controller is a three-state FSM: IDLE, EXEC, RESP.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid & req_ready`, register `req_a`/`req_b`/`req_func`/`req_tag`, load `cnt`=LATENCY-1, and go to EXEC.
- **EXEC**
  - `req_ready`=0. `alu_*` are driven from the operand registers and stay stable for the whole state.
  - When `cnt`≠0, decrement `cnt`.
  - When `cnt`=0, capture the response and go to RESP:
    - `rsp_result`←`alu_result` and `rsp_flags`←`alu_flags`, except for func 111.
    - For func 111: `rsp_result`=0, `rsp_flags`=0, `rsp_illegal`=1. The ALU outputs are ignored.
    - `fcsr_flags` |= captured flags.
    - If func=100: `cc`←`alu_result[2:0]`, where 001 means gt, 010 eq, 100 lt. `cc` is unchanged for all other funcs.
- **RESP**
  - `rsp_valid`=1 and all `rsp_*` are held stable.
  - On `rsp_ready`, go to IDLE. `rsp_valid` drops on the next cycle.
- `alu_num1`/`alu_num2`/`alu_func` keep their last value in IDLE and RESP. They are not zeroed.
- Flags pass through unmodified. The block does no arithmetic of its own.

## Timing

- **Reset** (asynchronous, any state, including mid-EXEC or RESP):
  - State goes to IDLE and any in-flight operation is dropped.
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0, `rsp_tag`=0, `rsp_illegal`=0.
  - `alu_num1`=0, `alu_num2`=0, `alu_func`=0.
  - `fcsr_flags`=0, `cc`=000.
  - `exc_trap`=0.
- **Latency:** a request accepted at edge N gives `rsp_valid`=1 after edge N+LATENCY.
- **Throughput:** with `rsp_ready` held high, one operation every LATENCY+2 cycles. There is no back-to-back acceptance, because `req_ready`=0 in EXEC and RESP.
- `req_ready` is a registered state decode. It does not depend combinationally on `req_valid`.
- **Backpressure:** with `rsp_ready`=0, RESP holds indefinitely and new requests are refused.
- **`fcsr_clr` on a capture edge:** the clear happens first, then the new flags are ORed in. `fcsr_flags` therefore equals the new capture's flags.
- `fcsr_clr` in any other cycle zeroes `fcsr_flags` at that edge.
- `exc_trap` is combinational from registered signals and asserts only while `rsp_valid`=1.

## Test plan

Use the real `FP_ALU` behind the controller, with LATENCY=1 unless stated otherwise.

- **Add, basic handshake:** a=0x41040000 (8.25), b=0x3FA00000 (1.25), func 000, tag 7.
  - Required: `rsp_valid` after 1 cycle with `rsp_result`=0x41180000 (9.5), flags=0, tag=7.
  - `req_ready` is low for exactly 2 cycles.
- **Div by zero and traps:** 8.25/0x00000000, func 011.
  - Required: `rsp_flags[3]`=1 and `fcsr_flags[3]`=1.
  - With `trap_en`=6'b001000, `exc_trap`=1 while `rsp_valid`.
  - Hold `rsp_ready`=0 for 5 cycles: outputs stay stable and `req_valid` is not accepted.
- **Compare:** -8.25 (0xC1040000) vs 1.5 (0x3FC00000), func 100 → `cc`=100.
  - Then -8.25 vs -8.25 → `cc`=010.
  - A following add leaves `cc`=010.
- **Sticky flags:**
  - inf (0x7F800000) + -inf (0xFF800000) → QNaN bit set in `fcsr_flags`.
  - A following clean add keeps it set.
  - `fcsr_clr` on the capture edge of a div-by-zero op → `fcsr_flags`=6'b001000.
- **Illegal op and latency:** func 111 → `rsp_illegal`=1, `rsp_result`=0, flags=0.
  - With LATENCY=4, `rsp_valid` rises exactly 4 edges after acceptance, and `alu_*` are stable throughout EXEC.
- **Reset mid-operation:** deassert `rst_n` during EXEC and during RESP.
  - Required: all outputs take their reset values immediately, `req_ready`=1 after release, and no stale response appears.

Source files
------------

// File: rtl/fp_alu_ctrl.sv
// fp_alu_ctrl: sequential front-end for the combinational FP_ALU.
// Takes one operation at a time over a valid/ready request port and holds the operands on
// the ALU for LATENCY cycles. It then captures the result and flags, presents them on a
// valid/ready response port, and keeps sticky FCSR flags and the compare condition bits.
// Flag order everywhere: {SNaN, QNaN, div_by_zero, inexact, underflow, overflow}.

module fp_alu_ctrl #(
    parameter int unsigned LATENCY = 1,  // legal range 1..15
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,

    // Request from the issue stage
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_func,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,

    // Combinational FP_ALU
    output logic [31:0]      alu_num1,
    output logic [31:0]      alu_num2,
    output logic [2:0]       alu_func,
    input  logic [31:0]      alu_result,
    input  logic [5:0]       alu_flags,

    // Response to the consumer
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [5:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_illegal,

    // Exceptions and status
    input  logic [5:0]       trap_en,
    output logic             exc_trap,
    output logic [5:0]       fcsr_flags,
    input  logic             fcsr_clr,
    output logic [2:0]       cc
);

    localparam logic [2:0] FuncCmp     = 3'b100;
    localparam logic [2:0] FuncIllegal = 3'b111;

    // Out-of-range LATENCY is clamped so the 4-bit settle counter can never wrap.
    localparam int unsigned LatClamped = (LATENCY < 1)  ? 1  :
                                         (LATENCY > 15) ? 15 : LATENCY;
    localparam logic [3:0]  CntLoad    = 4'(LatClamped - 1);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e           state_q;
    logic [3:0]       cnt_q;

    // Operand registers; these drive the ALU directly and only change on acceptance.
    logic [31:0]      num1_q;
    logic [31:0]      num2_q;
    logic [2:0]       func_q;
    logic [TAG_W-1:0] tag_q;

    // Registered handshake and response outputs
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_result_q;
    logic [5:0]       rsp_flags_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_illegal_q;

    // Architectural status
    logic [5:0]       fcsr_q;
    logic [2:0]       cc_q;

    // Capture-side values
    logic             is_illegal;
    logic             capture;
    logic [31:0]      cap_result;
    logic [5:0]       cap_flags;

    // Decode what would be captured this cycle; illegal ops mask the ALU outputs entirely.
    always_comb begin
        is_illegal = (func_q == FuncIllegal);
        capture    = (state_q == StExec) && (cnt_q == 4'd0);
        cap_result = is_illegal ? 32'd0 : alu_result;
        cap_flags  = is_illegal ? 6'd0  : alu_flags;
    end

    // Controller FSM with registered handshake, operand and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            num1_q        <= 32'd0;
            num2_q        <= 32'd0;
            func_q        <= 3'd0;
            tag_q         <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 32'd0;
            rsp_flags_q   <= 6'd0;
            rsp_tag_q     <= '0;
            rsp_illegal_q <= 1'b0;
            cc_q          <= 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready_q) begin
                        num1_q      <= req_a;
                        num2_q      <= req_b;
                        func_q      <= req_func;
                        tag_q       <= req_tag;
                        cnt_q       <= CntLoad;
                        req_ready_q <= 1'b0;
                        state_q     <= StExec;
                    end
                end
                StExec: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_result_q  <= cap_result;
                        rsp_flags_q   <= cap_flags;
                        rsp_tag_q     <= tag_q;
                        rsp_illegal_q <= is_illegal;
                        // ALU encodes compare outcome one-hot in result[2:0] as {lt, eq, gt}.
                        if (func_q == FuncCmp) begin
                            cc_q <= alu_result[2:0];
                        end
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    // Sticky flags: a clear on the capture edge wipes the old state before the new flags land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcsr_q <= 6'd0;
        end else if (capture) begin
            fcsr_q <= (fcsr_clr ? 6'd0 : fcsr_q) | cap_flags;
        end else if (fcsr_clr) begin
            fcsr_q <= 6'd0;
        end
    end

    // Output wiring; only the trap is combinational, and only from registered signals.
    always_comb begin
        req_ready   = req_ready_q;
        alu_num1    = num1_q;
        alu_num2    = num2_q;
        alu_func    = func_q;
        rsp_valid   = rsp_valid_q;
        rsp_result  = rsp_result_q;
        rsp_flags   = rsp_flags_q;
        rsp_tag     = rsp_tag_q;
        rsp_illegal = rsp_illegal_q;
        fcsr_flags  = fcsr_q;
        cc          = cc_q;
        exc_trap    = rsp_valid_q && |(rsp_flags_q & trap_en);
    end

`ifndef SYNTHESIS
    // A stalled response must not move.
    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid_q && !rsp_ready |=> rsp_valid_q && $stable(rsp_result_q) &&
            $stable(rsp_flags_q) && $stable(rsp_tag_q) && $stable(rsp_illegal_q));

    // Never accepting and responding at the same time.
    a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_ready_q && rsp_valid_q));

    // Operands stay put on the ALU for the whole settle window.
    a_alu_stable: assert property (@(posedge clk) disable iff (!rst_n)
        state_q == StExec |=> state_q != StExec ||
            ($stable(num1_q) && $stable(num2_q) && $stable(func_q)));

    a_trap_valid: assert property (@(posedge clk) disable iff (!rst_n)
        exc_trap |-> rsp_valid_q);
`endif

endmodule

// File: tb/tb_fp_alu_ctrl.sv
// Bench for fp_alu_ctrl: a table-driven FP_ALU stand-in, a transaction-level reference model
// checked every cycle, and directed scenarios with hand-computed literal expectations.

module tb_fp_alu_ctrl;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned ML    = 1;  // latency of the main instance

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main instance (LATENCY=1)
    logic             req_valid = 1'b0, req_ready;
    logic [2:0]       req_func = '0;
    logic [31:0]      req_a = '0, req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [31:0]      alu_num1, alu_num2, alu_result;
    logic [2:0]       alu_func;
    logic [5:0]       alu_flags;
    logic             rsp_valid, rsp_ready = 1'b1, rsp_illegal, exc_trap, fcsr_clr = 1'b0;
    logic [31:0]      rsp_result;
    logic [5:0]       rsp_flags, trap_en = '0, fcsr_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic [2:0]       cc;

    // Second instance (LATENCY=4)
    logic             q_req_valid = 1'b0, q_req_ready;
    logic [2:0]       q_req_func = '0;
    logic [31:0]      q_req_a = '0, q_req_b = '0;
    logic [TAG_W-1:0] q_req_tag = '0;
    logic [31:0]      q_alu_num1, q_alu_num2, q_alu_result;
    logic [2:0]       q_alu_func;
    logic [5:0]       q_alu_flags;
    logic             q_rsp_valid, q_rsp_ready = 1'b1, q_rsp_illegal, q_exc_trap;
    logic [31:0]      q_rsp_result;
    logic [5:0]       q_rsp_flags, q_fcsr_flags;
    logic [TAG_W-1:0] q_rsp_tag;
    logic [2:0]       q_cc;

    // FP_ALU stand-in: known IEEE results for the directed vectors; illegal func yields junk.
    function automatic logic [37:0] ref_alu(input logic [2:0] f, input logic [31:0] x,
                                            input logic [31:0] y);
        if (f == 3'b000 && x == 32'h41040000 && y == 32'h3FA00000) return {6'b0, 32'h41180000};
        if (f == 3'b000 && x == 32'h3F800000 && y == 32'h3F800000) return {6'b0, 32'h40000000};
        if (f == 3'b000 && x == 32'h7F800000 && y == 32'hFF800000)
            return {6'b010000, 32'h7FC00000};
        if (f == 3'b011 && x == 32'h41040000 && y == 32'h00000000)
            return {6'b001000, 32'h7F800000};
        if (f == 3'b100 && x == 32'hC1040000 && y == 32'h3FC00000) return {6'b0, 32'h4};
        if (f == 3'b100 && x == 32'hC1040000 && y == 32'hC1040000) return {6'b0, 32'h2};
        if (f == 3'b111) return {6'b111111, 32'hDEADBEEF};
        return {6'b0, x ^ y};
    endfunction

    assign {alu_flags, alu_result}     = ref_alu(alu_func, alu_num1, alu_num2);
    assign {q_alu_flags, q_alu_result} = ref_alu(q_alu_func, q_alu_num1, q_alu_num2);

    // What a completed operation must report: illegal ops report nothing from the ALU.
    function automatic logic [31:0] exp_res(input logic [2:0] f, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [37:0] t;
        t = ref_alu(f, x, y);
        return (f == 3'b111) ? 32'd0 : t[31:0];
    endfunction

    function automatic logic [5:0] exp_flg(input logic [2:0] f, input logic [31:0] x,
                                           input logic [31:0] y);
        logic [37:0] t;
        t = ref_alu(f, x, y);
        return (f == 3'b111) ? 6'd0 : t[37:32];
    endfunction

    function automatic logic [2:0] exp_cc(input logic [2:0] f, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [31:0] r;
        r = exp_res(f, x, y);
        return r[2:0];
    endfunction

    fp_alu_ctrl #(.LATENCY(ML), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_func(alu_func),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
        .trap_en(trap_en), .exc_trap(exc_trap), .fcsr_flags(fcsr_flags),
        .fcsr_clr(fcsr_clr), .cc(cc)
    );

    fp_alu_ctrl #(.LATENCY(4), .TAG_W(TAG_W)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(q_req_valid), .req_ready(q_req_ready), .req_func(q_req_func),
        .req_a(q_req_a), .req_b(q_req_b), .req_tag(q_req_tag),
        .alu_num1(q_alu_num1), .alu_num2(q_alu_num2), .alu_func(q_alu_func),
        .alu_result(q_alu_result), .alu_flags(q_alu_flags),
        .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready), .rsp_result(q_rsp_result),
        .rsp_flags(q_rsp_flags), .rsp_tag(q_rsp_tag), .rsp_illegal(q_rsp_illegal),
        .trap_en(6'b0), .exc_trap(q_exc_trap), .fcsr_flags(q_fcsr_flags),
        .fcsr_clr(1'b0), .cc(q_cc)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one op outstanding, done ML edges after acceptance.
    logic             m_busy, m_valid, m_ill;
    int unsigned      m_age;
    logic [31:0]      m_a, m_b, m_res;
    logic [2:0]       m_f, m_cc;
    logic [TAG_W-1:0] m_tag, m_rtag;
    logic [5:0]       m_flags, m_fcsr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_ill <= 1'b0; m_age <= 0;
            m_a <= '0; m_b <= '0; m_f <= '0; m_tag <= '0;
            m_res <= '0; m_flags <= '0; m_rtag <= '0; m_fcsr <= '0; m_cc <= '0;
        end else if (m_busy) begin
            if (m_age + 1 == ML) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_res   <= exp_res(m_f, m_a, m_b);
                m_flags <= exp_flg(m_f, m_a, m_b);
                m_rtag  <= m_tag;
                m_ill   <= (m_f == 3'b111);
                m_fcsr  <= (fcsr_clr ? 6'd0 : m_fcsr) | exp_flg(m_f, m_a, m_b);
                if (m_f == 3'b100) m_cc <= exp_cc(m_f, m_a, m_b);
            end else begin
                m_age <= m_age + 1;
                if (fcsr_clr) m_fcsr <= 6'd0;
            end
        end else begin
            if (fcsr_clr) m_fcsr <= 6'd0;
            if (m_valid) begin
                if (rsp_ready) m_valid <= 1'b0;
            end else if (req_valid) begin
                m_busy <= 1'b1; m_age <= 0;
                m_a <= req_a; m_b <= req_b; m_f <= req_func; m_tag <= req_tag;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_req_ready", req_ready, !(m_busy || m_valid));
            chk("m_rsp_valid", rsp_valid, m_valid);
            chk("m_fcsr", fcsr_flags, m_fcsr);
            chk("m_cc", cc, m_cc);
            chk("m_exc_trap", exc_trap, m_valid && |(m_flags & trap_en));
            if (m_valid) begin
                chk("m_rsp_result", rsp_result, m_res);
                chk("m_rsp_flags", rsp_flags, m_flags);
                chk("m_rsp_tag", rsp_tag, m_rtag);
                chk("m_rsp_illegal", rsp_illegal, m_ill);
            end
            if (m_busy) begin
                chk("m_alu_num1", alu_num1, m_a);
                chk("m_alu_num2", alu_num2, m_b);
                chk("m_alu_func", alu_func, m_f);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until an edge sees req_ready; returns 1 after that edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t);
        bit acc;
        acc = 1'b0;
        req_func = f; req_a = a; req_b = b; req_tag = t; req_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = req_ready;
            tick();
        end
        req_valid = 1'b0;
        chk("issue_accepted", acc, 1);
    endtask

    task automatic wait_rsp(input string nm);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk(nm, rsp_valid, 1);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_req_ready"}, req_ready, 1);
        chk({p, "_rsp_valid"}, rsp_valid, 0);
        chk({p, "_rsp_result"}, rsp_result, 0);
        chk({p, "_rsp_flags"}, rsp_flags, 0);
        chk({p, "_rsp_tag"}, rsp_tag, 0);
        chk({p, "_rsp_illegal"}, rsp_illegal, 0);
        chk({p, "_alu"}, {alu_num1, alu_num2, alu_func}, 0);
        chk({p, "_fcsr"}, fcsr_flags, 0);
        chk({p, "_cc"}, cc, 0);
        chk({p, "_exc_trap"}, exc_trap, 0);
    endtask

    initial begin
        #12;
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // Add with basic handshake; req_ready low for exactly two cycles
        issue(3'b000, 32'h41040000, 32'h3FA00000, 5'd7);
        chk("add_ready_exec", req_ready, 0);
        chk("add_valid_exec", rsp_valid, 0);
        tick();
        chk("add_valid", rsp_valid, 1);
        chk("add_result", rsp_result, 32'h41180000);
        chk("add_flags", rsp_flags, 0);
        chk("add_tag", rsp_tag, 7);
        chk("add_ready_resp", req_ready, 0);
        tick();
        chk("add_ready_back", req_ready, 1);
        chk("add_valid_drop", rsp_valid, 0);

        // Div by zero with trap enabled and response backpressure
        trap_en = 6'b001000;
        rsp_ready = 1'b0;
        issue(3'b011, 32'h41040000, 32'h00000000, 5'd2);
        wait_rsp("div_valid");
        chk("div_flag", rsp_flags[3], 1);
        chk("div_fcsr", fcsr_flags[3], 1);
        chk("div_trap", exc_trap, 1);
        req_func = 3'b000; req_a = 32'h3F800000; req_b = 32'h3F800000; req_tag = 5'd9;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_ready", req_ready, 0);
            chk("hold_result", rsp_result, 32'h7F800000);
            chk("hold_tag", rsp_tag, 2);
            chk("hold_trap", exc_trap, 1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("div_valid_drop", rsp_valid, 0);
        chk("div_trap_drop", exc_trap, 0);
        trap_en = 6'b0;

        // Compare: lt, then eq, then a non-compare op leaves cc alone
        issue(3'b100, 32'hC1040000, 32'h3FC00000, 5'd1);
        wait_rsp("cmp_lt_valid");
        chk("cmp_lt_cc", cc, 3'b100);
        tick();
        issue(3'b100, 32'hC1040000, 32'hC1040000, 5'd2);
        wait_rsp("cmp_eq_valid");
        chk("cmp_eq_cc", cc, 3'b010);
        tick();
        issue(3'b000, 32'h3F800000, 32'h3F800000, 5'd3);
        wait_rsp("cmp_add_valid");
        chk("cmp_add_result", rsp_result, 32'h40000000);
        chk("cmp_add_cc", cc, 3'b010);
        tick();

        // Sticky flags and clear-on-capture
        issue(3'b000, 32'h7F800000, 32'hFF800000, 5'd4);
        wait_rsp("nan_valid");
        chk("nan_result", rsp_result, 32'h7FC00000);
        chk("nan_fcsr_q", fcsr_flags[4], 1);
        tick();
        issue(3'b000, 32'h3F800000, 32'h3F800000, 5'd5);
        wait_rsp("clean_valid");
        chk("clean_fcsr", fcsr_flags, 6'b011000);
        tick();
        issue(3'b011, 32'h41040000, 32'h00000000, 5'd6);
        fcsr_clr = 1'b1;
        tick();
        fcsr_clr = 1'b0;
        chk("clr_cap_valid", rsp_valid, 1);
        chk("clr_cap_fcsr", fcsr_flags, 6'b001000);
        tick();
        fcsr_clr = 1'b1;
        tick();
        fcsr_clr = 1'b0;
        chk("clr_idle_fcsr", fcsr_flags, 6'b000000);

        // Illegal op masks the ALU
        issue(3'b111, 32'h12345678, 32'h9ABCDEF0, 5'd10);
        wait_rsp("ill_valid");
        chk("ill_flag", rsp_illegal, 1);
        chk("ill_result", rsp_result, 0);
        chk("ill_flags", rsp_flags, 0);
        chk("ill_fcsr", fcsr_flags, 0);
        chk("ill_cc", cc, 3'b010);
        tick();
        issue(3'b000, 32'h41040000, 32'h3FA00000, 5'd11);
        wait_rsp("post_ill_valid");
        chk("post_ill_flag", rsp_illegal, 0);
        tick();

        // Reset during EXEC
        issue(3'b011, 32'h41040000, 32'h00000000, 5'd12);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_exec");
        #3 rst_n = 1'b1;
        tick();
        tick();
        chk("rst_exec_no_stale", rsp_valid, 0);
        chk("rst_exec_ready", req_ready, 1);
        chk("rst_exec_fcsr", fcsr_flags, 0);

        // Reset during RESP
        rsp_ready = 1'b0;
        issue(3'b011, 32'h41040000, 32'h00000000, 5'd13);
        wait_rsp("rst_resp_valid");
        #2 rst_n = 1'b0;
        #1 check_reset("rst_resp");
        #3 rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_resp_no_stale", rsp_valid, 0);
        chk("rst_resp_ready", req_ready, 1);

        // LATENCY=4 instance: valid exactly 4 edges after acceptance, ALU held throughout
        q_req_func = 3'b000; q_req_a = 32'h41040000; q_req_b = 32'h3FA00000;
        q_req_tag = 5'd3; q_req_valid = 1'b1;
        chk("l4_ready", q_req_ready, 1);
        tick();
        q_req_valid = 1'b0;
        q_req_a = 32'h0; q_req_b = 32'h0; q_req_func = 3'b111;
        for (int k = 0; k < 4; k++) begin
            chk("l4_valid_low", q_rsp_valid, 0);
            chk("l4_ready_low", q_req_ready, 0);
            chk("l4_alu", {q_alu_num1, q_alu_num2, q_alu_func},
                {32'h41040000, 32'h3FA00000, 3'b000});
            tick();
        end
        chk("l4_valid", q_rsp_valid, 1);
        chk("l4_result", q_rsp_result, 32'h41180000);
        chk("l4_tag", q_rsp_tag, 3);
        tick();
        chk("l4_done", q_rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
